// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - single-outstanding load/store controller between Execute, WriteBack and a fixed-latency SRAM
module mem_ctrl #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [4:0]  req_rd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [4:0]  rsp_rd,
    output logic        rsp_write,
    output logic        rsp_fault,
    output logic        sram_en,
    output logic        sram_we,
    output logic [29:0] sram_addr,
    output logic [31:0] sram_wdata,
    output logic [3:0]  sram_wstrb,
    input  logic [31:0] sram_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_q;
    logic [1:0]  addr_lo_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [4:0]  rd_q;
    logic        write_q;
    logic [2:0]  cnt_q;
    logic        sram_en_q;
    logic        sram_we_q;
    logic [29:0] sram_addr_q;
    logic [31:0] sram_wdata_q;
    logic [3:0]  sram_wstrb_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic [4:0]  rsp_rd_q;
    logic        rsp_write_q;
    logic        rsp_fault_q;

    logic        fault_d;
    logic [3:0]  strb_d;
    logic [31:0] wdata_d;
    logic [7:0]  byte_d;
    logic [15:0] half_d;
    logic [31:0] load_d;

    always_comb begin
        fault_d = 1'b0;
        strb_d  = 4'b0000;
        wdata_d = req_wdata;
        case (req_size)
            2'b00: begin
                strb_d  = 4'b0001 << req_addr[1:0];
                wdata_d = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                fault_d = req_addr[0];
                strb_d  = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                fault_d = |req_addr[1:0];
                strb_d  = 4'b1111;
            end
            default: fault_d = 1'b1;
        endcase
        if (!req_write) begin
            strb_d = 4'b0000;
        end
    end

    // Lane selection and extension of the SRAM word as it arrives
    always_comb begin
        case (addr_lo_q)
            2'd0:    byte_d = sram_rdata[7:0];
            2'd1:    byte_d = sram_rdata[15:8];
            2'd2:    byte_d = sram_rdata[23:16];
            default: byte_d = sram_rdata[31:24];
        endcase
        half_d = addr_lo_q[1] ? sram_rdata[31:16] : sram_rdata[15:0];
        case (size_q)
            2'b00:   load_d = {{24{byte_d[7] & ~uns_q}}, byte_d};
            2'b01:   load_d = {{16{half_d[15] & ~uns_q}}, half_d};
            default: load_d = sram_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_lo_q    <= 2'b00;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            rd_q         <= 5'd0;
            write_q      <= 1'b0;
            cnt_q        <= 3'd0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= 30'd0;
            sram_wdata_q <= 32'd0;
            sram_wstrb_q <= 4'b0000;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'd0;
            rsp_rd_q     <= 5'd0;
            rsp_write_q  <= 1'b0;
            rsp_fault_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_lo_q <= req_addr[1:0];
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        rd_q      <= req_rd;
                        write_q   <= req_write;
                        if (fault_d) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_fault_q <= 1'b1;
                            rsp_rdata_q <= 32'd0;
                            rsp_rd_q    <= req_rd;
                            rsp_write_q <= req_write;
                        end else begin
                            state_q      <= ISSUE;
                            sram_en_q    <= 1'b1;
                            sram_we_q    <= req_write;
                            sram_addr_q  <= req_addr[31:2];
                            sram_wdata_q <= wdata_d;
                            sram_wstrb_q <= strb_d;
                        end
                    end
                end
                ISSUE: begin
                    sram_en_q <= 1'b0;
                    sram_we_q <= 1'b0;
                    cnt_q     <= 3'(LATENCY - 1);
                    if (write_q) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_fault_q <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        rsp_rd_q    <= rd_q;
                        rsp_write_q <= 1'b1;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_fault_q <= 1'b0;
                        rsp_rdata_q <= load_d;
                        rsp_rd_q    <= rd_q;
                        rsp_write_q <= write_q;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE) && !rst;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_rd     = rsp_rd_q;
    assign rsp_write  = rsp_write_q;
    assign rsp_fault  = rsp_fault_q;
    assign sram_en    = sram_en_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_wstrb = sram_wstrb_q;

endmodule
